// File: rtl/demux_1_8_pkg.sv
// Shared types and field layout for the 1:8 DEMUX request sequencer.
package demux_1_8_pkg;

    // Sequencer FSM states.
    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } seqState_e;

    // A queued request packs the destination above the data bit.
    localparam int ENTRY_W  = 4;
    localparam int DATA_BIT = 0;
    localparam int DEST_LSB = 1;
    localparam int DEST_MSB = 3;
    localparam int SEL_W    = 3;

    // Builds a FIFO entry from a destination index and a data bit.
    function automatic logic [ENTRY_W-1:0] packEntry(input logic [SEL_W-1:0] dest,
                                                     input logic             data);
        return {dest, data};
    endfunction

endpackage

// File: rtl/demux_1_8_seq_fifo.sv
// Small synchronous request FIFO with a separate occupancy counter.
module demux_1_8_seq_fifo
    import demux_1_8_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wrData,
    output logic [WIDTH-1:0]         rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [LVL_W-1:0] level_q;
    logic             doPush;
    logic             doPop;

    // Guard the strobes so a stray push-when-full or pop-when-empty cannot corrupt state.
    always_comb begin
        doPush = push & ~full;
        doPop  = pop & ~empty;
    end

    // Storage array carries no reset; only the pointers and count define validity.
    always_ff @(posedge clock) begin
        if (doPush) begin
            mem[wrPtr_q] <= wrData;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy counts up on push and down on pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Head of queue is visible without a pop so the FSM can load it on the same edge.
    always_comb begin
        rdData = mem[rdPtr_q];
        full   = (level_q == LVL_W'(DEPTH));
        empty  = (level_q == '0);
        level  = level_q;
    end

endmodule

// File: rtl/demux_1_8_sequencer.sv
// Buffers {dest, data} requests and presents them one at a time to a 1:8 DEMUX,
// holding each for HOLD_CYCLES clocks with no gap between queued requests.
module demux_1_8_sequencer
    import demux_1_8_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                         Clock_In,
    input  logic                         Reset_In,
    input  logic                         Valid_In,
    input  logic [SEL_W-1:0]             Dest_In,
    input  logic                         Data_In,
    output logic                         Ready_Out,
    output logic                         Enable_Out,
    output logic [SEL_W-1:0]             Select_Out,
    output logic                         Data_Out,
    output logic [$clog2(FIFO_DEPTH):0]  Level_Out,
    output logic                         Overflow_Out
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    seqState_e          state_q, state_d;
    logic [CNT_W-1:0]   holdCnt_q, holdCnt_d;
    logic               enable_q, enable_d;
    logic [SEL_W-1:0]   select_q, select_d;
    logic               data_q, data_d;
    logic               overflow_q, overflow_d;

    logic               fifoPush;
    logic               fifoPop;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [ENTRY_W-1:0] headEntry;
    logic [$clog2(FIFO_DEPTH):0] fifoLevel;

    demux_1_8_seq_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock  (Clock_In),
        .reset  (Reset_In),
        .push   (fifoPush),
        .pop    (fifoPop),
        .wrData (packEntry(Dest_In, Data_In)),
        .rdData (headEntry),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .level  (fifoLevel)
    );

    // Ready depends only on the registered occupancy, never on Valid_In.
    always_comb begin
        Ready_Out  = ~fifoFull;
        fifoPush   = Valid_In & ~fifoFull;
        overflow_d = overflow_q | (Valid_In & fifoFull);
    end

    // Next-state logic: load the head entry whenever the output slot is free or its hold expires.
    always_comb begin
        state_d   = state_q;
        holdCnt_d = holdCnt_q;
        enable_d  = enable_q;
        select_d  = select_q;
        data_d    = data_q;
        fifoPop   = 1'b0;
        case (state_q)
            IDLE: begin
                enable_d = 1'b0;
                select_d = '0;
                data_d   = 1'b0;
                if (!fifoEmpty) begin
                    fifoPop   = 1'b1;
                    holdCnt_d = HOLD_LOAD;
                    enable_d  = 1'b1;
                    select_d  = headEntry[DEST_MSB:DEST_LSB];
                    data_d    = headEntry[DATA_BIT];
                    state_d   = DRIVE;
                end
            end
            DRIVE: begin
                if (holdCnt_q != '0) begin
                    holdCnt_d = holdCnt_q - CNT_W'(1);
                end else if (!fifoEmpty) begin
                    fifoPop   = 1'b1;
                    holdCnt_d = HOLD_LOAD;
                    enable_d  = 1'b1;
                    select_d  = headEntry[DEST_MSB:DEST_LSB];
                    data_d    = headEntry[DATA_BIT];
                end else begin
                    enable_d = 1'b0;
                    select_d = '0;
                    data_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, hold counter, DEMUX drive registers and sticky overflow flag.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q    <= IDLE;
            holdCnt_q  <= '0;
            enable_q   <= 1'b0;
            select_q   <= '0;
            data_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            holdCnt_q  <= holdCnt_d;
            enable_q   <= enable_d;
            select_q   <= select_d;
            data_q     <= data_d;
            overflow_q <= overflow_d;
        end
    end

    // Every output comes straight from a register.
    always_comb begin
        Enable_Out   = enable_q;
        Select_Out   = select_q;
        Data_Out     = data_q;
        Level_Out    = fifoLevel;
        Overflow_Out = overflow_q;
    end

endmodule

// File: tb/tb_demux_1_8_sequencer.sv
// Directed bench: three sequencer instances (HOLD_CYCLES 1, 3, 4; FIFO_DEPTH 4) on one clock.
module tb_demux_1_8_sequencer;

    logic       clk = 1'b0;
    logic [2:0] rst;
    logic [2:0] valid;
    logic [2:0] dataIn;
    logic [2:0] destIn [3];
    logic [2:0] ready;
    logic [2:0] en;
    logic [2:0] sel [3];
    logic [2:0] dataOut;
    logic [2:0] level [3];
    logic [2:0] ovf;

    int checks = 0;
    int errors = 0;

    // Free-running clock shared by all instances.
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gDut
        demux_1_8_sequencer #(
            .FIFO_DEPTH  (4),
            .HOLD_CYCLES ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) dut (
            .Clock_In     (clk),
            .Reset_In     (rst[g]),
            .Valid_In     (valid[g]),
            .Dest_In      (destIn[g]),
            .Data_In      (dataIn[g]),
            .Ready_Out    (ready[g]),
            .Enable_Out   (en[g]),
            .Select_Out   (sel[g]),
            .Data_Out     (dataOut[g]),
            .Level_Out    (level[g]),
            .Overflow_Out (ovf[g])
        );
    end

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one instance's request inputs.
    task automatic applyStimulus(input int idx, input logic v, input logic [2:0] d, input logic b);
        valid[idx]  = v;
        destIn[idx] = d;
        dataIn[idx] = b;
    endtask

    // Single comparison with failure accounting.
    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the DEMUX drive triple of one instance.
    task automatic checkDrive(input string tag, input int idx, input logic e,
                              input logic [2:0] s, input logic d);
        checkOutput({tag, "_en"},  {7'd0, en[idx]}, {7'd0, e});
        checkOutput({tag, "_sel"}, {5'd0, sel[idx]}, {5'd0, s});
        checkOutput({tag, "_dat"}, {7'd0, dataOut[idx]}, {7'd0, d});
    endtask

    initial begin
        rst = 3'b111;
        for (int i = 0; i < 3; i++) applyStimulus(i, 0, 0, 0);

        // Reset state on every instance.
        tick();
        for (int i = 0; i < 3; i++) begin
            checkDrive($sformatf("rst%0d", i), i, 0, 0, 0);
            checkOutput($sformatf("rst%0d_rdy", i), {7'd0, ready[i]}, 8'd1);
            checkOutput($sformatf("rst%0d_lvl", i), {5'd0, level[i]}, 8'd0);
            checkOutput($sformatf("rst%0d_ovf", i), {7'd0, ovf[i]}, 8'd0);
        end
        rst = 3'b000;
        tick();

        // Single request, HOLD_CYCLES=1.
        applyStimulus(0, 1, 5, 1);
        tick();
        applyStimulus(0, 0, 0, 0);
        checkDrive("A_push", 0, 0, 0, 0);
        checkOutput("A_push_lvl", {5'd0, level[0]}, 8'd1);
        tick();
        checkDrive("A_hold", 0, 1, 5, 1);
        checkOutput("A_hold_lvl", {5'd0, level[0]}, 8'd0);
        tick();
        checkDrive("A_done", 0, 0, 0, 0);
        tick();
        checkDrive("A_idle", 0, 0, 0, 0);
        checkOutput("A_ovf", {7'd0, ovf[0]}, 8'd0);

        // Back-to-back, HOLD_CYCLES=3: dests 2,7,0 give nine contiguous enable cycles.
        applyStimulus(1, 1, 2, 1);
        tick();
        checkDrive("B_e0", 1, 0, 0, 0);
        checkOutput("B_e0_lvl", {5'd0, level[1]}, 8'd1);
        for (int e = 1; e <= 10; e++) begin
            if (e == 1)      applyStimulus(1, 1, 7, 0);
            else if (e == 2) applyStimulus(1, 1, 0, 1);
            else             applyStimulus(1, 0, 0, 0);
            tick();
            if (e <= 3)      checkDrive($sformatf("B_e%0d", e), 1, 1, 2, 1);
            else if (e <= 6) checkDrive($sformatf("B_e%0d", e), 1, 1, 7, 0);
            else if (e <= 9) checkDrive($sformatf("B_e%0d", e), 1, 1, 0, 1);
            else             checkDrive("B_idle", 1, 0, 0, 0);
        end

        // Simultaneous push/pop at level 2, HOLD_CYCLES=3.
        applyStimulus(1, 1, 1, 1); tick();
        applyStimulus(1, 1, 3, 0); tick();
        checkDrive("P_a", 1, 1, 1, 1);
        applyStimulus(1, 1, 4, 1); tick();
        checkOutput("P_lvl2", {5'd0, level[1]}, 8'd2);
        applyStimulus(1, 0, 0, 0); tick();
        checkOutput("P_lvl3", {5'd0, level[1]}, 8'd2);
        applyStimulus(1, 1, 6, 0); tick();
        applyStimulus(1, 0, 0, 0);
        checkOutput("P_simul_lvl", {5'd0, level[1]}, 8'd2);
        checkDrive("P_b", 1, 1, 3, 0);
        tick(); tick(); tick();
        checkDrive("P_c", 1, 1, 4, 1);
        checkOutput("P_c_lvl", {5'd0, level[1]}, 8'd1);
        tick(); tick(); tick();
        checkDrive("P_d", 1, 1, 6, 0);
        checkOutput("P_d_lvl", {5'd0, level[1]}, 8'd0);
        tick(); tick(); tick();
        checkDrive("P_idle", 1, 0, 0, 0);

        // Full/overflow, HOLD_CYCLES=4: six requests, one held across a not-ready edge.
        applyStimulus(2, 1, 0, 0); tick();
        checkOutput("F_lvl1", {5'd0, level[2]}, 8'd1);
        applyStimulus(2, 1, 1, 1); tick();
        checkDrive("F_e0", 2, 1, 0, 0);
        applyStimulus(2, 1, 2, 0); tick();
        applyStimulus(2, 1, 3, 1); tick();
        checkOutput("F_lvl3", {5'd0, level[2]}, 8'd3);
        checkOutput("F_rdy3", {7'd0, ready[2]}, 8'd1);
        applyStimulus(2, 1, 4, 0); tick();
        checkOutput("F_lvl4", {5'd0, level[2]}, 8'd4);
        checkOutput("F_rdy4", {7'd0, ready[2]}, 8'd0);
        checkOutput("F_ovf0", {7'd0, ovf[2]}, 8'd0);
        applyStimulus(2, 1, 5, 1); tick();
        checkOutput("F_ovf1", {7'd0, ovf[2]}, 8'd1);
        checkOutput("F_popLvl", {5'd0, level[2]}, 8'd3);
        checkOutput("F_popRdy", {7'd0, ready[2]}, 8'd1);
        checkDrive("F_e1", 2, 1, 1, 1);
        tick();
        applyStimulus(2, 0, 0, 0);
        checkOutput("F_refill", {5'd0, level[2]}, 8'd4);
        tick(); tick(); tick();
        checkDrive("F_e2", 2, 1, 2, 0);
        checkOutput("F_e2_lvl", {5'd0, level[2]}, 8'd3);
        tick(); tick(); tick(); tick();
        checkDrive("F_e3", 2, 1, 3, 1);
        tick(); tick(); tick(); tick();
        checkDrive("F_e4", 2, 1, 4, 0);
        tick(); tick(); tick(); tick();
        checkDrive("F_e5", 2, 1, 5, 1);
        tick(); tick(); tick(); tick();
        checkDrive("F_idle", 2, 0, 0, 0);
        checkOutput("F_ovfSticky", {7'd0, ovf[2]}, 8'd1);

        // Reset during DRIVE, HOLD_CYCLES=3, second hold cycle with three entries queued.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 1, 3'(k + 1), 1'(k));
            tick();
        end
        applyStimulus(1, 0, 0, 0);
        tick();
        checkDrive("R_pre", 1, 1, 2, 1);
        checkOutput("R_pre_lvl", {5'd0, level[1]}, 8'd3);
        #2;
        rst[1] = 1'b1;
        #1;
        checkDrive("R_async", 1, 0, 0, 0);
        checkOutput("R_async_lvl", {5'd0, level[1]}, 8'd0);
        checkOutput("R_async_rdy", {7'd0, ready[1]}, 8'd1);
        tick();
        rst[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checkOutput($sformatf("R_quiet%0d", k), {7'd0, en[1]}, 8'd0);
        end
        checkOutput("R_quiet_lvl", {5'd0, level[1]}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1_8_sequencer.md
# demux_1_8_sequencer

Upstream feeder for the 1:8 DEMUX. It accepts {destination, data-bit} requests over a valid/ready handshake and buffers them in a small FIFO. It then drives the DEMUX's Enable, Select and Data inputs for a programmable number of cycles per request. This serialises bursty multi-source requests into the strictly one-output-at-a-time stream the DEMUX needs.

## Interface
- FIFO_DEPTH, 4, request buffer entries; power of two, ≥ 2
- HOLD_CYCLES, 1, cycles each request is presented to the DEMUX; ≥ 1
- Clock_In  input  1  single clock, rising edge
- Reset_In  input  1  asynchronous, active-high reset
- Valid_In  input  1  request present
- Dest_In  input  3  target DEMUX output index 0..7
- Data_In  input  1  bit to route
- Ready_Out  output  1  request accepted on this edge if Valid_In=1
- Enable_Out  output  1  to DEMUX Enable_In
- Select_Out  output  3  to DEMUX Select_In
- Data_Out  output  1  to DEMUX Data_In
- Level_Out  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- Overflow_Out  output  1  sticky; Valid_In seen while Ready_Out=0

## Operation
- Push: on an edge with Valid_In & Ready_Out, {Dest_In, Data_In} is written at the FIFO tail.
- Ready_Out = (Level_Out < FIFO_DEPTH). It is derived from registered occupancy only; there is no combinational path from Valid_In.
- FSM states:
  - IDLE: Enable_Out=0, Select_Out=0, Data_Out=0. If the FIFO is non-empty, pop the head into the output register, load the hold counter with HOLD_CYCLES-1, and go to DRIVE.
  - DRIVE: Enable_Out=1; Select_Out and Data_Out come from the popped entry. While the counter > 0, decrement it. At 0:
    - FIFO non-empty: pop the next entry, reload the counter, stay in DRIVE (back-to-back, no gap).
    - FIFO empty: go to IDLE.
- Simultaneous push and pop on one edge: Level_Out is unchanged.
- Push when full is impossible because Ready_Out=0. A slot freed by a pop shows up as Ready_Out=1 only from the following cycle.
- Overflow_Out sets on any edge with Valid_In=1 & Ready_Out=0. The request is dropped and the flag holds until reset.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Occupancy is tracked in a separate counter.
- Dest_In is 3 bits, so every value is legal; the FSM has no default or error path for destinations.

## Timing
- Reset (asynchronous assert; deassert sampled at the next edge) forces:
  - state IDLE, FIFO empty, Level_Out=0, Ready_Out=1
  - Enable_Out=0, Select_Out=0, Data_Out=0, Overflow_Out=0
- Reset mid-DRIVE drops the in-flight entry and all queued entries.
- Latency: request pushed at edge N into an empty, idle block → Enable_Out=1 with that Select/Data from edge N+1 for HOLD_CYCLES cycles.
- Steady state throughput is one request per HOLD_CYCLES cycles.
- Select_Out and Data_Out change only on edges where Enable_Out is already 1 (back-to-back) or is rising. They never change while a hold is in progress.
- All outputs are registered; none has a combinational path from an input.

## Structure
- Package demux_1_8_pkg holds:
  - FSM state encodings (IDLE=0, DRIVE=1)
  - ENTRY_W=4 and the field offsets (data bit 0, dest bits 3:1)
  - SEL_W=3
- Sub-module demux_1_8_seq_fifo: a synchronous FIFO of width ENTRY_W and depth FIFO_DEPTH, with push, pop, full, empty and level. Same clock and asynchronous reset.
- Top level: FSM, hold counter, output registers, overflow flag.

## Test plan
- Reset check: assert Reset_In mid-cycle → all outputs 0 immediately, Ready_Out=1, Level_Out=0.
- Single request, HOLD_CYCLES=1: push dest=5, data=1 at edge N → Enable=1, Select=5, Data=1 during cycle N+1 only; Enable=0 from N+2.
- Back-to-back, HOLD_CYCLES=3: push dests 2, 7, 0 on consecutive edges → Enable stays high 9 cycles; Select is 2, 7, 0 for 3 cycles each; then IDLE.
- Full/overflow, FIFO_DEPTH=4, HOLD_CYCLES=4:
  - Push 6 requests continuously → Ready_Out=0 once Level_Out=4.
  - Push that is held, valid while not ready, is not lost; a push attempted while not ready sets Overflow_Out=1.
  - Pointers wrap correctly; order is preserved.
- Reset in DRIVE: assert Reset_In on the second hold cycle with 3 entries queued → Enable_Out=0 at once. After release, with no new pushes, Enable_Out stays 0.
- Simultaneous push/pop at Level_Out=2 → Level_Out stays 2 and the output sequence matches push order.
